hvac_sequencer: RTL and testbench
=================================

Name: hvac_sequencer

Overview:
- Sits between the air_cond thermostat (its heating/cooling outputs drive heat_req/cool_req) and the physical heater, cooler and fan enables.
- Sequences the plant: fan pre-run, minimum compressor/heater run time, fan post-run and anti-short-cycle rest period.
- Enforces mutual exclusion of heater and cooler.
- Provides a saturating run counter for status.

Parameters:
- FAN_LEAD, 2, cycles of fan-only before heater/cooler enable (>=1)
- MIN_ON, 8, minimum cycles heater/cooler stays on once enabled (>=1)
- FAN_LAG, 4, cycles of fan-only after heater/cooler disable (>=1)
- MIN_OFF, 6, rest cycles with everything off before a new request is accepted (>=1)
- CNT_W, 8, width of internal phase timer (must hold max parameter value)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  master enable; low requests shutdown
- heat_req  in  1  heating request from air_cond
- cool_req  in  1  cooling request from air_cond
- heater_on  out  1  heater enable, registered
- cooler_on  out  1  cooler enable, registered
- fan_on  out  1  fan enable, registered
- lockout  out  1  high while in REST
- state  out  3  current FSM state encoding (status)
- run_count  out  8  number of HEAT/COOL entries, saturates at 255

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; heater_on=cooler_on=fan_on=lockout=0; run_count=0; timer=0.
  - rst asserted mid-operation drops all outputs immediately; no post-run occurs.
- All outputs are registered and decoded from the next state, so outputs change on the same edge as state.
- Timer: cleared on every state entry, increments each cycle in a timed state. A phase ends on the edge where timer==PARAM-1, so the phase lasts exactly PARAM cycles.
- Request validity: a request is valid when enable=1 and exactly one of heat_req/cool_req is high. Both high is treated as no request.
- IDLE (all outputs 0):
  - valid request -> FAN_PRE; latch mode (heat or cool) in a mode register.
- FAN_PRE (fan_on=1):
  - if the latched request drops, the opposite request rises, or enable=0 -> IDLE. No rest period, since heater/cooler never ran.
  - else after FAN_LEAD cycles -> HEAT or COOL per mode; run_count += 1 (saturating).
- HEAT (heater_on=1, fan_on=1) / COOL (cooler_on=1, fan_on=1):
  - enable=0 -> FAN_POST on the next edge (overrides MIN_ON).
  - otherwise, once MIN_ON cycles have elapsed, leave when the own request is low or the opposite request is high -> FAN_POST.
  - request changes before MIN_ON elapses are ignored.
  - heater_on and cooler_on are never both 1, in any cycle.
- FAN_POST (fan_on=1):
  - after FAN_LAG cycles -> REST.
  - ignores all inputs, including enable.
- REST (all off, lockout=1):
  - after MIN_OFF cycles -> IDLE.
  - requests are ignored.
  - a request still held at exit is taken from IDLE one cycle later.
- Changeover heat->cool always traverses FAN_POST, REST, IDLE and FAN_PRE. There is no direct HEAT<->COOL arc.
- Illegal state encoding -> IDLE on the next edge.
- Latency from a valid request in IDLE:
  - fan_on rises 1 edge later.
  - heater_on/cooler_on rise 1+FAN_LEAD edges later.

Decomposition:
- hvac_pkg holds:
  - state localparams: IDLE=3'd0, FAN_PRE=3'd1, HEAT=3'd2, COOL=3'd3, FAN_POST=3'd4, REST=3'd5
  - mode constants: MODE_HEAT=1'b0, MODE_COOL=1'b1
- One sub-module, hvac_phase_timer: CNT_W up-counter with clear, enable and compare-to-length, producing a done pulse. The FSM stays in hvac_sequencer.

Test Plan:
1. Heat cycle: reset, enable=1, heat_req=1 for 30 cycles then 0 -> fan_on at edge 1, heater_on edges 3..32, fan-only edges 33..36, lockout edges 37..42, IDLE at 43, run_count=1.
2. Short request: heat_req pulsed for 4 cycles once heater_on is high -> heater_on held exactly MIN_ON=8 cycles, then FAN_POST/REST sequence.
3. Abort in FAN_PRE: cool_req=1 for 1 cycle -> fan_on high for 1 cycle, back to IDLE, cooler_on never 1, lockout never 1, run_count unchanged.
4. Changeover: in HEAT past MIN_ON, heat_req=0 and cool_req=1 in the same cycle -> heater off, 4 fan-only cycles, 6 lockout cycles, IDLE, then FAN_PRE and COOL. Check heater_on & cooler_on never both high.
5. Enable drop and both requests: enable=0 at HEAT cycle 2 -> FAN_POST next edge. Separately, heat_req=cool_req=1 in IDLE -> remains IDLE.
6. Async reset mid-COOL plus saturation: rst pulse between clock edges -> all outputs 0 immediately, run_count=0. Then 260 short cycles -> run_count=255.

Source files
------------

// File: rtl/hvac_pkg.sv
// Shared state encodings, mode constants and widths for the HVAC plant sequencer.
package hvac_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned RUN_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 3'd0,
        FAN_PRE  = 3'd1,
        HEAT     = 3'd2,
        COOL     = 3'd3,
        FAN_POST = 3'd4,
        REST     = 3'd5
    } state_t;

    localparam logic MODE_HEAT = 1'b0;
    localparam logic MODE_COOL = 1'b1;

    // Saturating increment for the status run counter.
    function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
        return (v == {RUN_W{1'b1}}) ? v : v + RUN_W'(1);
    endfunction

endpackage

// File: rtl/hvac_phase_timer.sv
// Phase timer: counts cycles within a state and flags the last cycle of a phase.
module hvac_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] len,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt;

    assign done_c = (cnt == len - CNT_W'(1));

    // Holds at the terminal count so done stays asserted until the next clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !done_c) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hvac_sequencer.sv
// HVAC plant sequencer: fan pre/post run, minimum on/off times and heat/cool
// mutual exclusion between the thermostat requests and the plant enables.
module hvac_sequencer
    import hvac_pkg::*;
#(
    parameter int unsigned FAN_LEAD = 2,
    parameter int unsigned MIN_ON   = 8,
    parameter int unsigned FAN_LAG  = 4,
    parameter int unsigned MIN_OFF  = 6,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               heat_req,
    input  logic               cool_req,
    output logic               heater_on,
    output logic               cooler_on,
    output logic               fan_on,
    output logic               lockout,
    output logic [STATE_W-1:0] state,
    output logic [RUN_W-1:0]   run_count
);

    state_t           state_q;
    state_t           state_n;
    logic             mode;
    logic             req_valid_c;
    logic             own_req_c;
    logic             opp_req_c;
    logic             timed_c;
    logic             tmr_done_c;
    logic [CNT_W-1:0] len_c;

    assign state       = state_q;
    assign req_valid_c = enable && (heat_req ^ cool_req);

    // Phase length and timer enable for the current state.
    always_comb begin
        len_c   = '0;
        timed_c = 1'b1;
        case (state_q)
            FAN_PRE:     len_c = CNT_W'(FAN_LEAD);
            HEAT, COOL:  len_c = CNT_W'(MIN_ON);
            FAN_POST:    len_c = CNT_W'(FAN_LAG);
            REST:        len_c = CNT_W'(MIN_OFF);
            default:     timed_c = 1'b0;
        endcase
    end

    hvac_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_n != state_q),
        .en     (timed_c),
        .len    (len_c),
        .done_c (tmr_done_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic; HEAT and COOL never connect directly.
    always_comb begin
        state_n   = state_q;
        own_req_c = (mode == MODE_HEAT) ? heat_req : cool_req;
        opp_req_c = (mode == MODE_HEAT) ? cool_req : heat_req;
        case (state_q)
            IDLE: begin
                if (req_valid_c) state_n = FAN_PRE;
            end
            FAN_PRE: begin
                if (!enable || !own_req_c || opp_req_c) state_n = IDLE;
                else if (tmr_done_c) state_n = (mode == MODE_COOL) ? COOL : HEAT;
            end
            HEAT: begin
                if (!enable) state_n = FAN_POST;
                else if (tmr_done_c && (!heat_req || cool_req)) state_n = FAN_POST;
            end
            COOL: begin
                if (!enable) state_n = FAN_POST;
                else if (tmr_done_c && (!cool_req || heat_req)) state_n = FAN_POST;
            end
            FAN_POST: begin
                if (tmr_done_c) state_n = REST;
            end
            REST: begin
                if (tmr_done_c) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs decoded from the next state so they move on the same edge as state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            heater_on <= 1'b0;
            cooler_on <= 1'b0;
            fan_on    <= 1'b0;
            lockout   <= 1'b0;
            mode      <= MODE_HEAT;
            run_count <= '0;
        end else begin
            heater_on <= (state_n == HEAT);
            cooler_on <= (state_n == COOL);
            fan_on    <= (state_n == FAN_PRE) || (state_n == HEAT) ||
                         (state_n == COOL)    || (state_n == FAN_POST);
            lockout   <= (state_n == REST);
            if (state_q == IDLE && state_n == FAN_PRE) begin
                mode <= cool_req ? MODE_COOL : MODE_HEAT;
            end
            if (state_q == FAN_PRE && (state_n == HEAT || state_n == COOL)) begin
                run_count <= sat_inc(run_count);
            end
        end
    end

endmodule

// File: tb/tb_hvac_sequencer.sv
// Directed bench for hvac_sequencer with default parameters (2/8/4/6).
module tb_hvac_sequencer;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       heat_req;
    logic       cool_req;
    logic       heater_on;
    logic       cooler_on;
    logic       fan_on;
    logic       lockout;
    logic [2:0] st;
    logic [7:0] run_count;

    int total = 0;
    int bad   = 0;

    hvac_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .heat_req  (heat_req),
        .cool_req  (cool_req),
        .heater_on (heater_on),
        .cooler_on (cooler_on),
        .fan_on    (fan_on),
        .lockout   (lockout),
        .state     (st),
        .run_count (run_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {heater,cooler,fan,lockout} for a given state encoding.
    function automatic logic [3:0] exp_outs(input logic [2:0] s);
        logic [3:0] o;
        o[3] = (s == 3'd2);
        o[2] = (s == 3'd3);
        o[1] = (s == 3'd1) || (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
        o[0] = (s == 3'd5);
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        enable   = 1'b0;
        heat_req = 1'b0;
        cool_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({st, heater_on, cooler_on, fan_on, lockout} !== 7'd0) begin
            bad++;
            $display("FAIL reset_state: got st=%0d outs=%b, want st=0 outs=0000", st,
                     {heater_on, cooler_on, fan_on, lockout});
        end
        total++;
        if (run_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_count: got %0d want 0", run_count);
        end
    endtask

    task automatic test_heat_cycle();
        logic [2:0] es;
        do_reset();
        enable   = 1'b1;
        heat_req = 1'b1;
        for (int e = 1; e <= 45; e++) begin
            tick();
            if (e == 32) heat_req = 1'b0;
            if (e <= 2)       es = 3'd1;
            else if (e <= 32) es = 3'd2;
            else if (e <= 36) es = 3'd4;
            else if (e <= 42) es = 3'd5;
            else              es = 3'd0;
            total++;
            if (st !== es || {heater_on, cooler_on, fan_on, lockout} !== exp_outs(es)) begin
                bad++;
                $display("FAIL heat_cycle edge %0d: got st=%0d outs=%b, want st=%0d outs=%b",
                         e, st, {heater_on, cooler_on, fan_on, lockout}, es, exp_outs(es));
            end
        end
        total++;
        if (run_count !== 8'd1) begin
            bad++;
            $display("FAIL heat_cycle_count: got %0d want 1", run_count);
        end
    endtask

    task automatic test_short_request();
        logic [2:0] es;
        do_reset();
        enable   = 1'b1;
        heat_req = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            tick();
            if (e == 6) heat_req = 1'b0;
            if (e <= 2)       es = 3'd1;
            else if (e <= 10) es = 3'd2;
            else if (e <= 14) es = 3'd4;
            else if (e <= 20) es = 3'd5;
            else              es = 3'd0;
            total++;
            if (st !== es || {heater_on, cooler_on, fan_on, lockout} !== exp_outs(es)) begin
                bad++;
                $display("FAIL short_req edge %0d: got st=%0d outs=%b, want st=%0d outs=%b",
                         e, st, {heater_on, cooler_on, fan_on, lockout}, es, exp_outs(es));
            end
        end
    endtask

    task automatic test_abort_fan_pre();
        logic [2:0] es;
        do_reset();
        enable   = 1'b1;
        cool_req = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            cool_req = 1'b0;
            es = (e == 1) ? 3'd1 : 3'd0;
            total++;
            if (st !== es || {heater_on, cooler_on, fan_on, lockout} !== exp_outs(es)) begin
                bad++;
                $display("FAIL abort edge %0d: got st=%0d outs=%b, want st=%0d outs=%b",
                         e, st, {heater_on, cooler_on, fan_on, lockout}, es, exp_outs(es));
            end
        end
        total++;
        if (run_count !== 8'd0) begin
            bad++;
            $display("FAIL abort_count: got %0d want 0", run_count);
        end
    endtask

    task automatic test_changeover();
        logic [2:0] es;
        do_reset();
        enable   = 1'b1;
        heat_req = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e == 12) begin
                heat_req = 1'b0;
                cool_req = 1'b1;
            end
            if (e <= 2)       es = 3'd1;
            else if (e <= 12) es = 3'd2;
            else if (e <= 16) es = 3'd4;
            else if (e <= 22) es = 3'd5;
            else if (e == 23) es = 3'd0;
            else if (e <= 25) es = 3'd1;
            else              es = 3'd3;
            total++;
            if (st !== es || {heater_on, cooler_on, fan_on, lockout} !== exp_outs(es)) begin
                bad++;
                $display("FAIL changeover edge %0d: got st=%0d outs=%b, want st=%0d outs=%b",
                         e, st, {heater_on, cooler_on, fan_on, lockout}, es, exp_outs(es));
            end
            total++;
            if ((heater_on & cooler_on) !== 1'b0) begin
                bad++;
                $display("FAIL exclusion edge %0d: heater=%b cooler=%b, want not both 1",
                         e, heater_on, cooler_on);
            end
        end
        total++;
        if (run_count !== 8'd2) begin
            bad++;
            $display("FAIL changeover_count: got %0d want 2", run_count);
        end
    endtask

    task automatic test_enable_and_both();
        logic [2:0] es;
        do_reset();
        enable   = 1'b1;
        heat_req = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 4) enable = 1'b0;
            if (e == 6) enable = 1'b1;
            if (e <= 2)      es = 3'd1;
            else if (e <= 4) es = 3'd2;
            else if (e <= 8) es = 3'd4;
            else             es = 3'd5;
            total++;
            if (st !== es || {heater_on, cooler_on, fan_on, lockout} !== exp_outs(es)) begin
                bad++;
                $display("FAIL enable_drop edge %0d: got st=%0d outs=%b, want st=%0d outs=%b",
                         e, st, {heater_on, cooler_on, fan_on, lockout}, es, exp_outs(es));
            end
        end
        do_reset();
        enable   = 1'b1;
        heat_req = 1'b1;
        cool_req = 1'b1;
        repeat (5) tick();
        total++;
        if ({st, heater_on, cooler_on, fan_on, lockout} !== 7'd0) begin
            bad++;
            $display("FAIL both_req: got st=%0d outs=%b, want st=0 outs=0000", st,
                     {heater_on, cooler_on, fan_on, lockout});
        end
    endtask

    task automatic test_async_reset_and_saturation();
        do_reset();
        enable   = 1'b1;
        cool_req = 1'b1;
        repeat (5) tick();
        total++;
        if (st !== 3'd3 || cooler_on !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_cool: got st=%0d cooler=%b, want st=3 cooler=1", st, cooler_on);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({st, heater_on, cooler_on, fan_on, lockout} !== 7'd0 || run_count !== 8'd0) begin
            bad++;
            $display("FAIL async_reset: got st=%0d outs=%b cnt=%0d, want all 0", st,
                     {heater_on, cooler_on, fan_on, lockout}, run_count);
        end
        cool_req = 1'b0;
        #1 rst = 1'b0;
        for (int i = 1; i <= 260; i++) begin
            heat_req = 1'b1;
            repeat (3) tick();
            heat_req = 1'b0;
            repeat (18) tick();
            if (i == 254 || i == 255 || i == 260) begin
                total++;
                if (run_count !== ((i < 255) ? 8'(i) : 8'd255)) begin
                    bad++;
                    $display("FAIL saturation after %0d runs: got %0d want %0d", i, run_count,
                             (i < 255) ? i : 255);
                end
            end
        end
        total++;
        if (st !== 3'd0) begin
            bad++;
            $display("FAIL saturation_idle: got st=%0d want 0", st);
        end
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        heat_req = 1'b0;
        cool_req = 1'b0;
        test_reset();
        test_heat_cycle();
        test_short_request();
        test_abort_fan_pre();
        test_changeover();
        test_enable_and_both();
        test_async_reset_and_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
